// File: rtl/t06_snake_pkg.sv
// Shared snake-game types and constants used by the wall-hit scanner.
package t06_snake_pkg;

    localparam int unsigned CELL_W        = 8;
    localparam int unsigned NUM_WALLS_DEF = 25;
    localparam int unsigned CNT_W_DEF     = 5;

    localparam logic [CELL_W-1:0] WALL_EMPTY = 8'h00;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // A wall slot holding 8'h00 is an unused entry.
    function automatic logic cell_occupied(input cell_t c);
        return c != cell_t'(WALL_EMPTY);
    endfunction

endpackage

// File: rtl/t06_wall_hit_scanner_if.sv
// Request/result bus between the snake controller and the wall-hit scanner.
interface t06_wall_hit_scanner_if #(
    parameter int unsigned CNT_W = t06_snake_pkg::CNT_W_DEF
);

    logic             check_req;
    logic [7:0]       check_head;
    logic             check_busy;
    logic             check_done;
    logic             wall_collision;
    logic [CNT_W-1:0] wall_count;

    // Requester side (snake controller).
    modport master (
        output check_req,
        output check_head,
        input  check_busy,
        input  check_done,
        input  wall_collision,
        input  wall_count
    );

    // Scanner side.
    modport slave (
        input  check_req,
        input  check_head,
        output check_busy,
        output check_done,
        output wall_collision,
        output wall_count
    );

endinterface

// File: rtl/t06_wall_hit_scanner.sv
// Snapshots the wall list on request and scans one slot per cycle, reporting
// whether the proposed head cell hits a wall and how many slots are occupied.
module t06_wall_hit_scanner
    import t06_snake_pkg::*;
#(
    parameter int unsigned NUM_WALLS = NUM_WALLS_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                          system_clk,
    input  logic                          nreset,
    input  logic                          enable_in,
    input  logic [NUM_WALLS*CELL_W-1:0]   wall_locations,
    t06_wall_hit_scanner_if.slave         bus
);

    localparam int unsigned IDX_W = $clog2(NUM_WALLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WALLS - 1);

    state_e                    state, state_nxt;
    cell_t [NUM_WALLS-1:0]     snap, snap_nxt;
    cell_t                     head, head_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic                      hit, hit_nxt;
    logic [CNT_W-1:0]          acc, acc_nxt;
    logic                      busy, busy_nxt;
    logic                      done, done_nxt;
    logic                      collision, collision_nxt;
    logic [CNT_W-1:0]          count, count_nxt;

    cell_t                     slot;
    logic                      slot_used;

    // State and datapath registers; reset drops any pending check.
    always_ff @(posedge system_clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            snap      <= '0;
            head      <= '0;
            idx       <= '0;
            hit       <= 1'b0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            snap      <= snap_nxt;
            head      <= head_nxt;
            idx       <= idx_nxt;
            hit       <= hit_nxt;
            acc       <= acc_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            collision <= collision_nxt;
            count     <= count_nxt;
        end
    end

    // Next-state and next-output logic; one snapshot slot evaluated per SCAN cycle.
    always_comb begin
        state_nxt     = state;
        snap_nxt      = snap;
        head_nxt      = head;
        idx_nxt       = idx;
        hit_nxt       = hit;
        acc_nxt       = acc;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        collision_nxt = collision;
        count_nxt     = count;

        slot      = snap[idx];
        slot_used = cell_occupied(slot);

        if (!enable_in) begin
            // Wall mode off: abandon any scan and clear the reported results.
            state_nxt     = IDLE;
            busy_nxt      = 1'b0;
            collision_nxt = 1'b0;
            count_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.check_req) begin
                        state_nxt = SCAN;
                        snap_nxt  = wall_locations;
                        head_nxt  = cell_t'(bus.check_head);
                        idx_nxt   = '0;
                        hit_nxt   = 1'b0;
                        acc_nxt   = '0;
                        busy_nxt  = 1'b1;
                    end
                end
                SCAN: begin
                    if (slot_used) begin
                        acc_nxt = acc + CNT_W'(1);
                        if (slot == head) begin
                            hit_nxt = 1'b1;
                        end
                    end
                    idx_nxt = idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        // Last slot: publish the accumulators including this slot.
                        state_nxt     = DONE;
                        busy_nxt      = 1'b0;
                        done_nxt      = 1'b1;
                        collision_nxt = hit_nxt;
                        count_nxt     = acc_nxt;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign bus.check_busy     = busy;
    assign bus.check_done     = done;
    assign bus.wall_collision = collision;
    assign bus.wall_count     = count;

endmodule
